// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Holds one operation at a time: accept, let the ALU settle, then present the result.
//
// state | meaning
// IDLE  | arbitrating; req_gnt driven combinationally, ALU ports held at zero
// EXEC  | operands latched and driving the ALU; settle counter running
// RESP  | result captured; rsp_valid[owner] high until the owner takes it
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  input  logic [4:0]  req_shamt0,
  input  logic [4:0]  req_shamt1,
  input  logic [1:0]  req_shiftv,
  input  logic [1:0]  req_chkov,
  output logic [1:0]  req_gnt,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_ov,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shift,
  output logic        alu_shiftv,
  output logic        alu_judge,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow
);

  localparam logic [1:0] CNT_INIT = 2'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ptr;
  logic        r_owner;
  logic [1:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_shamt;
  logic        r_shiftv;
  logic        r_chkov;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic        r_rsp_ov;

  logic [1:0]  w_gnt;
  logic        w_take;
  logic        w_win;
  logic        w_busy;

  // Grant is gated by the reset pin so nothing is offered while reset is held.
  always_comb begin
    w_gnt = 2'b00;
    if (reset && (r_state == ST_IDLE)) begin
      if (req_valid == 2'b11) begin
        w_gnt = r_ptr ? 2'b10 : 2'b01;
      end else begin
        w_gnt = req_valid;
      end
    end
  end

  assign w_take  = |w_gnt;
  assign w_win   = w_gnt[1];
  assign req_gnt = w_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 1'b0;
      r_owner      <= 1'b0;
      r_cnt        <= 2'd0;
      r_op         <= 4'd0;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_shamt      <= 5'd0;
      r_shiftv     <= 1'b0;
      r_chkov      <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_rsp_result <= 32'd0;
      r_rsp_ov     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_owner  <= w_win;
            r_op     <= w_win ? req_op1    : req_op0;
            r_a      <= w_win ? req_a1     : req_a0;
            r_b      <= w_win ? req_b1     : req_b0;
            r_shamt  <= w_win ? req_shamt1 : req_shamt0;
            r_shiftv <= req_shiftv[w_win];
            r_chkov  <= req_chkov[w_win];
            r_cnt    <= CNT_INIT;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == 2'd0) begin
            r_rsp_result <= alu_result;
            r_rsp_ov     <= alu_overflow & r_chkov;
            r_rsp_valid  <= r_owner ? 2'b10 : 2'b01;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          // Pointer moves only when the operation retires, so the loser wins next.
          if (rsp_ready[r_owner]) begin
            r_rsp_valid <= 2'b00;
            r_ptr       <= ~r_owner;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_busy = (r_state != ST_IDLE);

  assign alu_op     = w_busy ? r_op     : 4'd0;
  assign alu_a      = w_busy ? r_a      : 32'd0;
  assign alu_b      = w_busy ? r_b      : 32'd0;
  assign alu_shift  = w_busy ? r_shamt  : 5'd0;
  assign alu_shiftv = w_busy & r_shiftv;
  assign alu_judge  = w_busy & r_chkov;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_ov     = r_rsp_ov;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_CYCLES=1, one with 3,
// each wrapped around a small behavioural ALU; the idle instance is held in reset.
module tb_alu_arbiter;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, sel3;
  logic [1:0]  req_valid, req_shiftv, req_chkov, rsp_ready;
  logic [3:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1;
  logic [4:0]  sh0, sh1;

  logic [1:0]  gnt1, rv1, gnt3, rv3;
  logic [31:0] res1, res3, aa1, aa3, ab1, ab3, ar1, ar3;
  logic        ov1, ov3, ashv1, ashv3, ajd1, ajd3, aov1, aov3;
  logic [3:0]  aop1, aop3;
  logic [4:0]  ash1, ash3;

  function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh,
                                            input logic shv);
    logic [31:0] r;
    logic        o;
    logic [4:0]  s;
    s = shv ? a[4:0] : sh;
    r = 32'd0;
    o = 1'b0;
    case (op)
      ALU_ADDU: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUBU: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_SLL:  r = b << s;
      default:  r = 32'd0;
    endcase
    return {o, r};
  endfunction

  assign {aov1, ar1} = alu_model(aop1, aa1, ab1, ash1, ashv1);
  assign {aov3, ar3} = alu_model(aop3, aa3, ab3, ash3, ashv3);

  alu_arbiter #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst1), .req_valid(req_valid),
    .req_op0(op0), .req_op1(op1), .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
    .req_shamt0(sh0), .req_shamt1(sh1), .req_shiftv(req_shiftv), .req_chkov(req_chkov),
    .req_gnt(gnt1), .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_result(res1), .rsp_ov(ov1),
    .alu_op(aop1), .alu_a(aa1), .alu_b(ab1), .alu_shift(ash1), .alu_shiftv(ashv1),
    .alu_judge(ajd1), .alu_result(ar1), .alu_overflow(aov1)
  );

  alu_arbiter #(.EXEC_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst3), .req_valid(req_valid),
    .req_op0(op0), .req_op1(op1), .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
    .req_shamt0(sh0), .req_shamt1(sh1), .req_shiftv(req_shiftv), .req_chkov(req_chkov),
    .req_gnt(gnt3), .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_result(res3), .rsp_ov(ov3),
    .alu_op(aop3), .alu_a(aa3), .alu_b(ab3), .alu_shift(ash3), .alu_shiftv(ashv3),
    .alu_judge(ajd3), .alu_result(ar3), .alu_overflow(aov3)
  );

  logic [1:0]  gnt, rv;
  logic [31:0] res, aa, ab;
  logic        ov;
  logic [3:0]  aop;
  assign gnt = sel3 ? gnt3 : gnt1;
  assign rv  = sel3 ? rv3  : rv1;
  assign res = sel3 ? res3 : res1;
  assign ov  = sel3 ? ov3  : ov1;
  assign aa  = sel3 ? aa3  : aa1;
  assign ab  = sel3 ? ab3  : ab1;
  assign aop = sel3 ? aop3 : aop1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op on requester i, wait for its grant and response, retire it.
  task automatic run_op(input int i, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic shv,
                        input logic ck, output logic [31:0] r, output logic o,
                        output int lat);
    int n;
    if (i == 0) begin op0 = op; a0 = a; b0 = b; sh0 = sh; end
    else        begin op1 = op; a1 = a; b1 = b; sh1 = sh; end
    req_shiftv[i] = shv;
    req_chkov[i]  = ck;
    req_valid[i]  = 1'b1;
    n = 0;
    #1;
    while (!gnt[i] && n < 10) begin @(negedge clk); #1; n++; end
    chk("op_grant", 32'(gnt[i]), 32'd1);
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 1;
    #1;
    while (!rv[i] && lat < 20) begin @(negedge clk); #1; lat++; end
    chk("op_rsp_valid", 32'(rv[i]), 32'd1);
    r = res;
    o = ov;
    @(negedge clk);
  endtask

  logic [31:0] r;
  logic        o;
  int          lat;
  logic        seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sel3 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b11; req_shiftv = 2'b00; req_chkov = 2'b00;
    op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0; sh0 = '0; sh1 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rv), 32'd0);
    chk("rst_result", res, 32'd0);
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_alu_a", aa, 32'd0);

    // Basic ADDU, EXEC_CYCLES=1
    @(negedge clk);
    req_valid = 2'b00; rst1 = 1'b1;
    op0 = ALU_ADDU; a0 = 32'd7; b0 = 32'd5; req_valid = 2'b01;
    #1;
    chk("add_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("add_exec_rv", 32'(rv), 32'd0);
    chk("add_exec_gnt", 32'(gnt), 32'd0);
    chk("add_alu_op", 32'(aop), 32'(ALU_ADDU));
    chk("add_alu_a", aa, 32'd7);
    chk("add_alu_b", ab, 32'd5);
    @(negedge clk);
    #1;
    chk("add_rv", 32'(rv), 32'd1);
    chk("add_result", res, 32'd12);
    chk("add_ov", 32'(ov), 32'd0);
    @(negedge clk);
    #1;
    chk("add_idle_rv", 32'(rv), 32'd0);
    chk("add_idle_alu_a", aa, 32'd0);

    // Overflow with and without the check enable
    run_op(0, ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b1, r, o, lat);
    chk("ovf_result", r, 32'h8000_0000);
    chk("ovf_ov", 32'(o), 32'd1);
    chk("ovf_latency", 32'(lat), 32'd2);
    run_op(0, ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, r, o, lat);
    chk("ovf_nochk_result", r, 32'h8000_0000);
    chk("ovf_nochk_ov", 32'(o), 32'd0);

    // Both requesting continuously: alternate 0,1,0,1 three cycles apart
    rst1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    op0 = ALU_ADDU; a0 = 32'd1; b0 = 32'd2; op1 = ALU_ADDU; a1 = 32'd3; b1 = 32'd4;
    req_chkov = 2'b00; req_valid = 2'b11;
    #1;
    for (int k = 0; k < 12; k++) begin
      chk("alt_gnt", 32'(gnt), ((k % 3) != 0) ? 32'd0 : (((k / 3) % 2) != 0 ? 32'd2 : 32'd1));
      @(negedge clk);
      #1;
    end

    // Requester 1 SLL with delayed ready; requester 0 waits; non-owner ready ignored
    op1 = ALU_SLL; a1 = 32'd0; b1 = 32'd1; sh1 = 5'd4; req_shiftv = 2'b00;
    req_valid = 2'b10; rsp_ready = 2'b01;
    #1;
    chk("hold_gnt1", 32'(gnt), 32'd2);
    @(negedge clk);
    op0 = ALU_ADDU; a0 = 32'd1; b0 = 32'd1; req_valid = 2'b01;
    #1;
    chk("hold_exec_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_rv", 32'(rv), 32'd2);
      chk("hold_result", res, 32'd16);
      chk("hold_gnt", 32'(gnt), 32'd0);
      if (k == 4) rsp_ready = 2'b11;
      @(negedge clk);
      #1;
    end
    chk("hold_release_rv", 32'(rv), 32'd0);
    chk("hold_release_gnt0", 32'(gnt), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("pend_rv", 32'(rv), 32'd1);
    chk("pend_result", res, 32'd2);
    @(negedge clk);

    // EXEC_CYCLES=3 instance
    rst1 = 1'b0; sel3 = 1'b1; rst3 = 1'b1;
    run_op(0, ALU_SUBU, 32'd3, 32'd5, 5'd0, 1'b0, 1'b0, r, o, lat);
    chk("sub3_result", r, 32'hFFFF_FFFE);
    chk("sub3_latency", 32'(lat), 32'd4);
    chk("sub3_ov", 32'(o), 32'd0);

    // Reset pulse during EXEC aborts the operation
    op0 = ALU_SUBU; a0 = 32'd9; b0 = 32'd2; req_valid = 2'b01;
    #1;
    chk("abort_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("abort_in_exec_op", 32'(aop), 32'(ALU_SUBU));
    rst3 = 1'b0;
    #2;
    chk("abort_rst_rv", 32'(rv), 32'd0);
    chk("abort_rst_alu_op", 32'(aop), 32'd0);
    @(negedge clk);
    rst3 = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (rv != 2'b00) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    chk("abort_idle_alu_op", 32'(aop), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("abort_ptr_zero", 32'(gnt), 32'd1);
    req_valid = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1: ALU settle cycles before result capture; legal range 1..4.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 req_valid[1:0]  in  2  requester i has an operation pending.
REQ-005 req_op0/req_op1  in  4 each  ALUOp code (ALU_ADDU..ALU_SRA encodings from head.v).
REQ-006 req_a0/req_a1, req_b0/req_b1  in  32 each  operands A and B.
REQ-007 req_shamt0/req_shamt1  in  5 each; req_shiftv[1:0]  in  2; req_chkov[1:0]  in  2  shift amount, variable-shift select, overflow-check enable.
REQ-008 req_gnt[1:0]  out  2  one-hot accept; request i consumed in the cycle req_valid[i] & req_gnt[i].
REQ-009 rsp_valid[1:0]  out  2  result ready for requester i.
REQ-010 rsp_ready[1:0]  in  2  requester i takes result.
REQ-011 rsp_result  out  32; rsp_ov  out  1  shared response payload, meaningful only where rsp_valid set.
REQ-012 alu_op 4, alu_a 32, alu_b 32, alu_shift 5, alu_shiftv 1, alu_judge 1  out  drive shared ALU.
REQ-013 alu_result  in  32; alu_overflow  in  1  shared ALU outputs (combinational).

Function
REQ-014 FSM states: IDLE, EXEC, RESP; exactly one active.
REQ-015 IDLE: req_gnt combinational; if any req_valid, grant exactly one per round-robin pointer, else req_gnt=0.
REQ-016 Round robin: pointer names the preferred requester; on grant to i, pointer becomes 1-i at RESP exit; single requester granted regardless of pointer.
REQ-017 On grant: latch op, a, b, shamt, shiftv, chkov and owner index into operand registers; next state EXEC; settle counter loaded with EXEC_CYCLES-1.
REQ-018 EXEC and RESP: req_gnt=0; new requests wait, req inputs ignored.
REQ-019 ALU ports driven only from operand registers; in IDLE alu_op=0, alu_a=alu_b=0, alu_shift=0, alu_shiftv=0, alu_judge=0.
REQ-020 EXEC: counter decrements each cycle; in the cycle counter==0, capture alu_result into rsp_result and (alu_overflow & latched chkov) into rsp_ov, next state RESP.
REQ-021 Latency: grant cycle N -> rsp_valid first high cycle N+1+EXEC_CYCLES.
REQ-022 RESP: rsp_valid[owner]=1, other bit 0; payload stable until rsp_ready[owner]=1; then IDLE next cycle.
REQ-023 rsp_ready of non-owner ignored; rsp_ready while rsp_valid low ignored.
REQ-024 Minimum occupancy per operation: EXEC_CYCLES+2 cycles (grant, EXEC, RESP with immediate ready).
REQ-025 Simultaneous req_valid=2'b11 in IDLE: pointer decides; the loser keeps req_valid and wins the next IDLE cycle.
REQ-026 Requester deasserting req_valid in same cycle as gnt edge: grant already taken, operation completes.
REQ-027 rsp_ov is never set when latched chkov=0, regardless of alu_overflow.
REQ-028 ALU ops passed unchanged; no decode or width change inside block.

Reset
REQ-029 reset low: state=IDLE, pointer=0, counter=0, operand registers=0, rsp_result=0, rsp_ov=0, rsp_valid=0; req_gnt follows IDLE rule only after reset high.
REQ-030 req_gnt=0 while reset low.
REQ-031 Reset mid-EXEC or mid-RESP aborts operation; no rsp_valid produced for it after release.

Verification
REQ-032 EXEC_CYCLES=1, req0 ADDU a=7 b=5, rsp_ready0=1 -> gnt0 cycle N, rsp_valid=2'b01 cycle N+2, rsp_result=12, rsp_ov=0.
REQ-033 req0 ADDU a=0x7FFFFFFF b=1 chkov=1 -> rsp_result=0x80000000, rsp_ov=1; same with chkov=0 -> rsp_ov=0.
REQ-034 Both requesting continuously after reset, immediate rsp_ready -> grants alternate 0,1,0,1; each op 3 cycles apart.
REQ-035 req1 SLL b=1 shamt=4, rsp_ready1 held 0 for 5 cycles -> rsp_valid=2'b10, rsp_result=16 stable all 5 cycles; req0 pending not granted until after release.
REQ-036 EXEC_CYCLES=3, req0 SUBU a=3 b=5 -> rsp_valid at N+4, rsp_result=0xFFFFFFFE; reset pulsed in EXEC -> rsp_valid never set, state IDLE, pointer 0.
